// File: rtl/ap_ctrl_seq_pkg.sv
// Shared types for the ap_ctrl_hs transaction sequencer: FSM state encoding
// and the default-width counter type.
package ap_ctrl_seq_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_DONE,
      ST_GAP,
      ST_FINISH
   } seq_state_e;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/ap_ctrl_lat_tracker.sv
// Min/max transaction latency registers, cleared at the start of every run;
// min is seeded by the first completed transaction of the run.
module ap_ctrl_lat_tracker
   import ap_ctrl_seq_pkg::*;
#(
   parameter int CNT_W = $bits(cnt_t)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_upd,
   input  logic             i_first,
   input  logic [CNT_W-1:0] i_lat,
   output logic [CNT_W-1:0] o_min_lat,
   output logic [CNT_W-1:0] o_max_lat
);

   logic [CNT_W-1:0] r_min_lat;
   logic [CNT_W-1:0] r_max_lat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_min_lat <= '0;
         r_max_lat <= '0;
      end else if (i_clear) begin
         r_min_lat <= '0;
         r_max_lat <= '0;
      end else if (i_upd) begin
         if (i_first || (i_lat < r_min_lat)) r_min_lat <= i_lat;
         if (i_lat > r_max_lat)              r_max_lat <= i_lat;
      end
   end

   assign o_min_lat = r_min_lat;
   assign o_max_lat = r_max_lat;

endmodule

// File: rtl/ap_ctrl_txn_sequencer.sv
// Non-overlapped ap_ctrl_hs driver: issues NUM_TXN transactions per run with a
// watchdog. Define LATENCY_STATS_EN to add min_lat/max_lat outputs.
module ap_ctrl_txn_sequencer
   import ap_ctrl_seq_pkg::*;
#(
   parameter int NUM_TXN     = 16,
   parameter int IDLE_GAP    = 0,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = $bits(cnt_t)
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             go,
   output logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   output logic             ap_continue,
   output logic             busy,
   output logic             finish,
   output logic [CNT_W-1:0] txn_issued,
   output logic [CNT_W-1:0] txn_done,
   output logic [CNT_W-1:0] last_lat,
   output logic             timeout_err
`ifdef LATENCY_STATS_EN
   ,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat
`endif
);

   localparam logic [CNT_W-1:0] LP_NUM_TXN  = CNT_W'(NUM_TXN);
   localparam logic [CNT_W-1:0] LP_LAT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam int               GAP_W       = (IDLE_GAP > 2) ? $clog2(IDLE_GAP) : 1;
   localparam logic [GAP_W-1:0] LP_GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   seq_state_e       r_state;
   logic [CNT_W-1:0] r_lat_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_ap_start;
   logic             r_ap_continue;
   logic             r_busy;
   logic             r_finish;
   logic [CNT_W-1:0] r_txn_issued;
   logic [CNT_W-1:0] r_txn_done;
   logic [CNT_W-1:0] r_last_lat;
   logic             r_timeout_err;

   logic             w_go_ok;
   logic             w_ready_hit;
   logic             w_done_hit;
   logic [CNT_W-1:0] w_txn_done_nx;

   assign w_go_ok       = go && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
   assign w_ready_hit   = (r_state == ST_START) && ap_ready;
   // A done in START only counts alongside ready (combinational HLS top).
   assign w_done_hit    = (w_ready_hit && ap_done) || ((r_state == ST_WAIT_DONE) && ap_done);
   assign w_txn_done_nx = sat_inc(r_txn_done);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state       <= ST_IDLE;
         r_lat_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_ap_start    <= 1'b0;
         r_ap_continue <= 1'b1;
         r_busy        <= 1'b0;
         r_finish      <= 1'b0;
         r_txn_issued  <= '0;
         r_txn_done    <= '0;
         r_last_lat    <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_ap_continue <= 1'b1;
         case (r_state)
            ST_IDLE, ST_FINISH: begin
               if (w_go_ok) begin
                  r_state       <= ST_START;
                  r_ap_start    <= 1'b1;
                  r_busy        <= 1'b1;
                  r_finish      <= 1'b0;
                  r_lat_cnt     <= '0;
                  r_txn_issued  <= '0;
                  r_txn_done    <= '0;
                  r_last_lat    <= '0;
                  r_timeout_err <= 1'b0;
               end
            end
            ST_START, ST_WAIT_DONE: begin
               r_lat_cnt <= sat_inc(r_lat_cnt);
               if (w_ready_hit) r_txn_issued <= sat_inc(r_txn_issued);
               if (w_done_hit) begin
                  r_txn_done <= w_txn_done_nx;
                  r_last_lat <= r_lat_cnt;
                  if (w_txn_done_nx == LP_NUM_TXN) begin
                     r_state    <= ST_FINISH;
                     r_ap_start <= 1'b0;
                     r_busy     <= 1'b0;
                     r_finish   <= 1'b1;
                  end else if (IDLE_GAP == 0) begin
                     r_state    <= ST_START;
                     r_ap_start <= 1'b1;
                     r_lat_cnt  <= '0;
                  end else begin
                     r_state    <= ST_GAP;
                     r_ap_start <= 1'b0;
                     r_gap_cnt  <= '0;
                  end
               end else if (r_lat_cnt == LP_LAT_LAST) begin
                  r_state       <= ST_FINISH;
                  r_ap_start    <= 1'b0;
                  r_busy        <= 1'b0;
                  r_finish      <= 1'b1;
                  r_timeout_err <= 1'b1;
               end else if (w_ready_hit) begin
                  r_state    <= ST_WAIT_DONE;
                  r_ap_start <= 1'b0;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == LP_GAP_LAST) begin
                  r_state    <= ST_START;
                  r_ap_start <= 1'b1;
                  r_lat_cnt  <= '0;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_ap_start <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign ap_start    = r_ap_start;
   assign ap_continue = r_ap_continue;
   assign busy        = r_busy;
   assign finish      = r_finish;
   assign txn_issued  = r_txn_issued;
   assign txn_done    = r_txn_done;
   assign last_lat    = r_last_lat;
   assign timeout_err = r_timeout_err;

`ifdef LATENCY_STATS_EN
   logic w_txn_first;
   assign w_txn_first = (r_txn_done == '0);

   ap_ctrl_lat_tracker #(
      .CNT_W (CNT_W)
   ) u_lat (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .i_clear   (w_go_ok),
      .i_upd     (w_done_hit),
      .i_first   (w_txn_first),
      .i_lat     (r_lat_cnt),
      .o_min_lat (min_lat),
      .o_max_lat (max_lat)
   );
`endif

endmodule

// File: tb/tb_ap_ctrl_txn_sequencer.sv
// Bench for ap_ctrl_txn_sequencer: per-run timeline plans are expanded into
// expected per-cycle outputs, then replayed and compared every cycle.
module tb_ap_ctrl_txn_sequencer;

   localparam int NUM_TXN = 4;
   localparam int IDLE_GAP = 2;
   localparam int TO = 8;
   localparam int CNT_W = 16;
   localparam int NC = 2000;

   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   logic go = 1'b0;
   logic ap_ready = 1'b0;
   logic ap_done = 1'b0;
   logic ap_start, ap_continue, busy, finish, timeout_err;
   logic [CNT_W-1:0] txn_issued, txn_done, last_lat;
`ifdef LATENCY_STATS_EN
   logic [CNT_W-1:0] min_lat, max_lat;
`endif

   always #5 ap_clk = ~ap_clk;

   ap_ctrl_txn_sequencer #(
      .NUM_TXN     (NUM_TXN),
      .IDLE_GAP    (IDLE_GAP),
      .TIMEOUT_CYC (TO),
      .CNT_W       (CNT_W)
   ) dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .go          (go),
      .ap_start    (ap_start),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .ap_continue (ap_continue),
      .busy        (busy),
      .finish      (finish),
      .txn_issued  (txn_issued),
      .txn_done    (txn_done),
      .last_lat    (last_lat),
      .timeout_err (timeout_err)
`ifdef LATENCY_STATS_EN
      ,
      .min_lat     (min_lat),
      .max_lat     (max_lat)
`endif
   );

   // stimulus per cycle
   bit rst_low[NC], go_at[NC], ready_at[NC], done_at[NC];
   // expected outputs per cycle
   bit e_start[NC], e_busy[NC], e_finish[NC], e_err[NC];
   int e_issued[NC], e_done[NC], e_last[NC], e_min[NC], e_max[NC];

   int m_issued, m_done, m_last, m_min, m_max;
   bit m_busy, m_finish, m_err;
   int p_r[NUM_TXN], p_d[NUM_TXN];

   int n_cmp = 0, n_bad = 0;
   int cur_cyc = 0, last_cyc = 0;
   int cA, gB, cB, gD, cE, cF;

   task automatic chk(input string nm, input int c, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, c, act, exp);
      end
   endtask

   task automatic reset_model();
      m_issued = 0; m_done = 0; m_last = 0; m_min = 0; m_max = 0;
      m_busy = 0; m_finish = 0; m_err = 0;
   endtask

   task automatic put(input int c, input bit st);
      e_start[c] = st;      e_busy[c] = m_busy;   e_finish[c] = m_finish;
      e_err[c] = m_err;     e_issued[c] = m_issued; e_done[c] = m_done;
      e_last[c] = m_last;   e_min[c] = m_min;     e_max[c] = m_max;
   endtask

   task automatic hold(input int a, input int b, input bit noise);
      for (int c = a; c <= b; c++) begin
         put(c, 1'b0);
         if (noise && $urandom_range(0, 4) == 0) done_at[c] = 1'b1;
      end
   endtask

   // Expand one run (plan in p_r/p_d, p_d<0 = never done) starting with go in cycle g.
   task automatic run_plan(input int g, input bit noise, output int f);
      int s, e, rc;
      bit timed, rdy;
      go_at[g] = 1'b1;
      reset_model();
      m_busy = 1'b1;
      s = g + 1;
      f = -1;
      for (int k = 0; k < NUM_TXN && f < 0; k++) begin
         timed = (p_d[k] < 0) || (p_d[k] > TO - 1);
         e = timed ? s + TO - 1 : s + p_d[k];
         rc = s + p_r[k];
         rdy = (rc <= e);
         for (int c = s; c <= e; c++) begin
            put(c, !rdy || (c <= rc));
            if (noise && $urandom_range(0, 7) == 0) go_at[c] = 1'b1;
            if (rdy && c == rc) begin
               ready_at[c] = 1'b1;
               m_issued++;
            end
         end
         if (timed) begin
            m_err = 1'b1; m_busy = 1'b0; m_finish = 1'b1;
            f = e + 1;
         end else begin
            done_at[e] = 1'b1;
            if (m_done == 0 || p_d[k] < m_min) m_min = p_d[k];
            if (p_d[k] > m_max) m_max = p_d[k];
            m_done++;
            m_last = p_d[k];
            if (m_done == NUM_TXN) begin
               m_busy = 1'b0; m_finish = 1'b1;
               f = e + 1;
            end else begin
               for (int c = e + 1; c <= e + IDLE_GAP; c++) begin
                  put(c, 1'b0);
                  if (noise && $urandom_range(0, 3) == 0) done_at[c] = 1'b1;
                  if (noise && $urandom_range(0, 3) == 0) go_at[c] = 1'b1;
               end
               s = e + 1 + IDLE_GAP;
            end
         end
      end
   endtask

   task automatic build();
      int g, f, r;
      reset_model();
      for (int c = 0; c < 3; c++) rst_low[c] = 1'b1;
      g = 12;
      hold(0, g, 1'b1);
      // combinational HLS top
      for (int k = 0; k < NUM_TXN; k++) begin p_r[k] = 0; p_d[k] = 0; end
      run_plan(g, 1'b0, f); cA = f;
      g = f + 4; hold(f, g, 1'b1);
      // ready at 3, done at 5
      for (int k = 0; k < NUM_TXN; k++) begin p_r[k] = 3; p_d[k] = 5; end
      gB = g;
      run_plan(g, 1'b0, f); cB = f;
      g = f + 4; hold(f, g, 1'b0);
      // never done
      for (int k = 0; k < NUM_TXN; k++) begin p_r[k] = 1; p_d[k] = -1; end
      gD = g;
      run_plan(g, 1'b1, f);
      g = f + 5; hold(f, g, 1'b1);
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < NUM_TXN; k++) begin
            p_r[k] = int'($urandom_range(0, 3));
            p_d[k] = int'($urandom_range(7, p_r[k]));
            if ($urandom_range(0, 11) == 0) p_d[k] = -1;
         end
         run_plan(g, 1'b1, f);
         g = f + int'($urandom_range(2, 6)); hold(f, g, 1'b1);
      end
      // reset asserted while waiting for done of the first transaction
      for (int k = 0; k < NUM_TXN; k++) begin p_r[k] = 1; p_d[k] = 6; end
      run_plan(g, 1'b0, f);
      r = g + 4; cE = r;
      for (int c = r; c <= f + 8; c++) begin
         go_at[c] = 1'b0; ready_at[c] = 1'b0; done_at[c] = 1'b0;
      end
      for (int c = r; c < r + 3; c++) rst_low[c] = 1'b1;
      reset_model();
      g = r + 6; hold(r, g, 1'b1);
      for (int k = 0; k < NUM_TXN; k++) begin
         p_r[k] = int'($urandom_range(0, 2));
         p_d[k] = int'($urandom_range(6, p_r[k]));
      end
      run_plan(g, 1'b1, f);
      g = f + 3; hold(f, g, 1'b1);
      // latency spread, go pulses during the run
      p_r[0] = 0; p_r[1] = 1; p_r[2] = 1; p_r[3] = 2;
      p_d[0] = 2; p_d[1] = 7; p_d[2] = 4; p_d[3] = 4;
      run_plan(g, 1'b1, f); cF = f;
      hold(f, f + 4, 1'b1);
      last_cyc = f + 4;
   endtask

   initial begin
      build();
      if (last_cyc >= NC) begin
         $display("FAIL build cycles=%0d limit=%0d", last_cyc, NC);
         $fatal(1);
      end
      fork
         begin : drive
            for (int c = 0; c <= last_cyc; c++) begin
               @(posedge ap_clk);
               cur_cyc = c;
               #1;
               ap_rst_n = !rst_low[c];
               go       = go_at[c];
               ap_ready = ready_at[c];
               ap_done  = done_at[c];
            end
         end
         begin : compare
            int c, rise1, rise2, fall1, nrise;
            bit prev_start;
            prev_start = 1'b0; nrise = 0; rise1 = 0; rise2 = 0; fall1 = 0;
            for (int i = 0; i <= last_cyc; i++) begin
               @(negedge ap_clk);
               c = cur_cyc;
               chk("ap_start", c, ap_start, e_start[c]);
               chk("ap_continue", c, ap_continue, 1);
               chk("busy", c, busy, e_busy[c]);
               chk("finish", c, finish, e_finish[c]);
               chk("timeout_err", c, timeout_err, e_err[c]);
               chk("txn_issued", c, txn_issued, e_issued[c]);
               chk("txn_done", c, txn_done, e_done[c]);
               chk("last_lat", c, last_lat, e_last[c]);
`ifdef LATENCY_STATS_EN
               chk("min_lat", c, min_lat, e_min[c]);
               chk("max_lat", c, max_lat, e_max[c]);
`endif
               if (c == 1) begin
                  chk("rst_ap_start", c, ap_start, 0);
                  chk("rst_finish", c, finish, 0);
               end
               if (c == cA) begin
                  chk("comb_issued", c, txn_issued, 4);
                  chk("comb_done", c, txn_done, 4);
                  chk("comb_last_lat", c, last_lat, 0);
                  chk("comb_finish", c, finish, 1);
                  chk("comb_busy", c, busy, 0);
               end
               if (c > gB && c <= cB) begin
                  if (ap_start && !prev_start) begin
                     nrise++;
                     if (nrise == 1) rise1 = c;
                     if (nrise == 2) rise2 = c;
                  end
                  if (!ap_start && prev_start && nrise == 1) fall1 = c;
               end
               if (c == cB) begin
                  chk("slow_last_lat", c, last_lat, 5);
                  chk("slow_start_width", c, fall1 - rise1, 4);
                  chk("slow_gap_after_done", c, rise2 - (rise1 + 5) - 1, 2);
               end
               if (c == gD + 8) chk("wdog_err_early", c, timeout_err, 0);
               if (c == gD + 9) begin
                  chk("wdog_err", c, timeout_err, 1);
                  chk("wdog_start", c, ap_start, 0);
                  chk("wdog_finish", c, finish, 1);
                  chk("wdog_done", c, txn_done, 0);
               end
               if (c == cE) begin
                  chk("midrst_start", c, ap_start, 0);
                  chk("midrst_busy", c, busy, 0);
                  chk("midrst_issued", c, txn_issued, 0);
               end
               if (c == cF) begin
                  chk("lat_last", c, last_lat, 4);
`ifdef LATENCY_STATS_EN
                  chk("lat_min", c, min_lat, 2);
                  chk("lat_max", c, max_lat, 7);
`endif
               end
               prev_start = ap_start;
            end
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
